// File: rtl/sc1_port_pkg.sv
// Shared definitions for the sc1 CPU port to UART bridge: status bit positions,
// the registered request record, TX state encoding and the status word packer.
package sc1_port_pkg;

    localparam int ACK_BIT   = 31;
    localparam int FULL_BIT  = 30;
    localparam int BUSY_BIT  = 29;
    localparam int COUNT_LSB = 8;
    localparam int DATA_LSB  = 0;
    localparam int REQ_BIT   = 31;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

    typedef struct packed {
        logic       toggle;
        logic [7:0] data;
    } req_t;

    // The count field is up to 8 bits wide; narrower counts arrive zero-extended.
    function automatic logic [31:0] pack_status(
        input logic       ack,
        input logic       full,
        input logic       busy,
        input logic [7:0] count
    );
        logic [31:0] word;
        word                 = '0;
        word[ACK_BIT]        = ack;
        word[FULL_BIT]       = full;
        word[BUSY_BIT]       = busy;
        word[COUNT_LSB +: 8] = count;
        return word;
    endfunction

endpackage

// File: rtl/sc1_byte_fifo.sv
// Register-array byte FIFO with a combinational head. Full is judged before any
// same-edge pop, so a push into a full FIFO is always refused.
module sc1_byte_fifo #(
    parameter int FIFO_DEPTH_BITS = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [7:0]               din,
    input  logic                     pop,
    output logic [7:0]               dout,
    output logic [FIFO_DEPTH_BITS:0] count,
    output logic                     full,
    output logic                     empty
);

    localparam int DEPTH = 1 << FIFO_DEPTH_BITS;
    localparam logic [FIFO_DEPTH_BITS:0] CAPACITY = (FIFO_DEPTH_BITS + 1)'(DEPTH);

    logic [7:0]                 mem_q [DEPTH];
    logic [FIFO_DEPTH_BITS-1:0] wr_ptr_q;
    logic [FIFO_DEPTH_BITS-1:0] rd_ptr_q;
    logic [FIFO_DEPTH_BITS:0]   count_q;
    logic                       push_ok;
    logic                       pop_ok;

    assign full    = (count_q == CAPACITY);
    assign empty   = (count_q == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign dout    = mem_q[rd_ptr_q];
    assign count   = count_q;

    // NOTE: storage has no reset; occupancy is tracked by the pointers and count,
    // so stale entries are never observed and the array maps onto plain flops/RAM.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/sc1_port_uart_tx.sv
// Bridges sc1_cpu OUT writes (toggle handshake) into a byte FIFO and an 8N1 UART
// transmitter; ack, status and FIFO fill are returned on the CPU IN port.
module sc1_port_uart_tx
    import sc1_port_pkg::*;
#(
    parameter int CLKS_PER_BIT    = 434,
    parameter int FIFO_DEPTH_BITS = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] port_out,
    output logic [31:0] port_in,
    output logic        uart_tx
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int CNT_W  = FIFO_DEPTH_BITS + 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  FIFO_CAP  = CNT_W'(1 << FIFO_DEPTH_BITS);

    req_t              req_d1_q, req_d1_d;
    logic              seen_q, seen_d;
    tx_state_e         state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [7:0]        shift_q, shift_d;
    logic              tx_q, tx_d;
    logic [31:0]       port_in_q, port_in_d;

    logic              accept;
    logic              fifo_pop;
    logic [7:0]        fifo_dout;
    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W-1:0]  count_nx;
    logic              fifo_full;
    logic              fifo_empty;
    logic              baud_done;
    logic [BAUD_W-1:0] baud_run;
    logic              unused_port_bits;

    assign unused_port_bits = ^port_out[REQ_BIT-1:DATA_LSB+8];

    assign req_d1_d.toggle = port_out[REQ_BIT];
    assign req_d1_d.data   = port_out[DATA_LSB +: 8];

    // A request is pending until its toggle value has been pushed; a full FIFO
    // simply holds it off, so nothing is ever dropped.
    assign accept = (req_d1_q.toggle != seen_q) & ~fifo_full;
    assign seen_d = accept ? req_d1_q.toggle : seen_q;

    sc1_byte_fifo #(
        .FIFO_DEPTH_BITS(FIFO_DEPTH_BITS)
    ) u_fifo (
        .clk    (clk),
        .reset_n(reset_n),
        .push   (accept),
        .din    (req_d1_q.data),
        .pop    (fifo_pop),
        .dout   (fifo_dout),
        .count  (fifo_count),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    assign baud_done = (baud_q == BAUD_LAST);
    assign baud_run  = baud_done ? '0 : baud_q + 1'b1;

    // NOTE: every output gets a default before the case so no path leaves a
    // variable unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_run;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        fifo_pop  = 1'b0;
        case (state_q)
            IDLE: begin
                baud_d = '0;
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    shift_d   = fifo_dout;
                    bit_idx_d = '0;
                    state_d   = START;
                end
            end
            START: begin
                if (baud_done) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (baud_done) begin
                    shift_d = shift_q >> 1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
            end
            STOP: begin
                if (baud_done) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                baud_d  = '0;
            end
        endcase
    end

    // The line level is decoded from the next state so the pin comes straight off a flop.
    always_comb begin
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_comb begin
        case ({accept, fifo_pop})
            2'b10:   count_nx = fifo_count + 1'b1;
            2'b01:   count_nx = fifo_count - 1'b1;
            default: count_nx = fifo_count;
        endcase
        port_in_d = pack_status(
            accept ? req_d1_q.toggle : port_in_q[ACK_BIT],
            count_nx == FIFO_CAP,
            (count_nx != '0) | (state_d != IDLE),
            8'(count_nx)
        );
    end

    // NOTE: state flops use non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            req_d1_q  <= '0;
            seen_q    <= 1'b0;
            state_q   <= IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
            port_in_q <= '0;
        end else begin
            req_d1_q  <= req_d1_d;
            seen_q    <= seen_d;
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            port_in_q <= port_in_d;
        end
    end

    assign port_in = port_in_q;
    assign uart_tx = tx_q;

endmodule

// File: tb/tb_sc1_port_uart_tx.sv
// Directed bench for sc1_port_uart_tx: a vector table for reset, ack latency and
// stale toggles, then hand-written back-to-back, full-FIFO, push/pop and reset cases.
module tb_sc1_port_uart_tx;

    localparam int C = 4;
    localparam int D = 2;

    typedef struct {
        string       name;
        logic [31:0] po;
        logic [31:0] exp_pi;
        logic        exp_tx;
    } vec_t;

    logic        clk;
    logic        reset_n;
    logic [31:0] port_out;
    logic [31:0] port_in;
    logic        uart_tx;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic tb_tog = 1'b0;

    logic [7:0] rx_q[$];
    int         fall_q[$];
    logic       rx_prev = 1'b1;
    logic       rx_busy = 1'b0;
    int         rx_start = 0;
    int         rx_bit = 0;
    logic [7:0] rx_byte = '0;

    sc1_port_uart_tx #(
        .CLKS_PER_BIT(C),
        .FIFO_DEPTH_BITS(D)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .port_out(port_out),
        .port_in (port_in),
        .uart_tx (uart_tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Line monitor: detects each start-bit fall and samples every bit mid-cell.
    always @(negedge clk) begin
        if (rx_busy) begin
            if (cyc == rx_start + rx_bit * C + C / 2) begin
                if (rx_bit >= 1 && rx_bit <= 8) rx_byte[rx_bit-1] = uart_tx;
                rx_bit++;
                if (rx_bit == 10) begin
                    rx_busy = 1'b0;
                    rx_q.push_back(rx_byte);
                end
            end
        end else if (rx_prev && !uart_tx) begin
            rx_busy  = 1'b1;
            rx_start = cyc;
            rx_bit   = 0;
            fall_q.push_back(cyc);
        end
        rx_prev = uart_tx;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input bit chk_lat);
        int n;
        tb_tog   = ~tb_tog;
        port_out = {tb_tog, 23'd0, b};
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (port_in[31] != tb_tog && n < 100);
        check($sformatf("ack_%02h", b), {31'd0, port_in[31]}, {31'd0, tb_tog});
        if (chk_lat) check($sformatf("ack_latency_%02h", b), n, 2);
    endtask

    task automatic wait_rx(input int n, input int limit, input string name);
        int k;
        k = 0;
        while (rx_q.size() < n && k < limit) begin
            @(negedge clk);
            k++;
        end
        check(name, rx_q.size(), n);
    endtask

    task automatic wait_idle(input int limit);
        int k;
        k = 0;
        while (port_in[29] && k < limit) begin
            @(negedge clk);
            k++;
        end
        check("idle_wait", {31'd0, port_in[29]}, 0);
    endtask

    // Checks the remaining 10*C-1 line samples of a frame whose start sample was already taken.
    task automatic frame_rest(input logic [7:0] b);
        int   idx;
        logic exp;
        for (int k = 1; k < 10 * C; k++) begin
            @(negedge clk);
            idx = k / C;
            if (idx == 0) exp = 1'b0;
            else if (idx == 9) exp = 1'b1;
            else exp = b[idx-1];
            check($sformatf("frame_k%0d", k), {31'd0, uart_tx}, {31'd0, exp});
        end
    endtask

    vec_t vecs[6];

    initial begin
        int base, fbase, s, n, early;

        vecs[0] = '{"stale_lo_12", 32'h0000_0012, 32'h0000_0000, 1'b1};
        vecs[1] = '{"stale_lo_34", 32'h0000_0034, 32'h0000_0000, 1'b1};
        vecs[2] = '{"ignored_bits", 32'h7FFF_FFAB, 32'h0000_0000, 1'b1};
        vecs[3] = '{"req_capture", 32'h8000_0055, 32'h0000_0000, 1'b1};
        vecs[4] = '{"push_ack", 32'h8000_0055, 32'hA000_0100, 1'b1};
        vecs[5] = '{"pop_start", 32'h8000_0055, 32'hA000_0000, 1'b0};

        reset_n  = 1'b0;
        port_out = '0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("reset_port_in", port_in, 32'h0);
        check("reset_tx", {31'd0, uart_tx}, 1);

        for (int i = 0; i < 6; i++) begin
            port_out = vecs[i].po;
            @(negedge clk);
            check({vecs[i].name, "_pi"}, port_in, vecs[i].exp_pi);
            check({vecs[i].name, "_tx"}, {31'd0, uart_tx}, {31'd0, vecs[i].exp_tx});
        end
        tb_tog = 1'b1;
        frame_rest(8'h55);
        @(negedge clk);
        check("post_frame_pi", port_in, 32'h8000_0000);
        check("post_frame_tx", {31'd0, uart_tx}, 1);

        // Stale toggle with changing data must not start anything.
        for (int i = 0; i < 3; i++) begin
            port_out = {1'b1, 23'd0, 8'(8'h10 + i)};
            repeat (3) @(negedge clk);
            check($sformatf("stale_hi_pi%0d", i), port_in, 32'h8000_0000);
            check($sformatf("stale_hi_tx%0d", i), {31'd0, uart_tx}, 1);
        end

        // Back-to-back frames.
        base  = rx_q.size();
        fbase = fall_q.size();
        send(8'hA5, 1'b1);
        send(8'h3C, 1'b1);
        wait_rx(base + 2, 200, "b2b_rx_count");
        check("b2b_byte0", {24'd0, rx_q[base]}, 32'hA5);
        check("b2b_byte1", {24'd0, rx_q[base+1]}, 32'h3C);
        check("b2b_fall_gap", fall_q[fbase+1] - fall_q[fbase], 41);
        wait_idle(200);

        // Full FIFO: one byte in flight, four buffered, sixth held off.
        base = rx_q.size();
        send(8'h01, 1'b1);
        send(8'h80, 1'b1);
        send(8'hFF, 1'b1);
        send(8'h00, 1'b1);
        send(8'hC3, 1'b1);
        check("full_flag", {31'd0, port_in[30]}, 1);
        check("full_count", {29'd0, port_in[10:8]}, 4);
        tb_tog   = ~tb_tog;
        port_out = {tb_tog, 23'd0, 8'h7E};
        early = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (port_in[31] == tb_tog) early++;
        end
        check("full_no_early_ack", early, 0);
        check("full_still_full", {31'd0, port_in[30]}, 1);
        n = 0;
        while (port_in[31] != tb_tog && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("full_late_ack", {31'd0, port_in[31]}, {31'd0, tb_tog});
        check("full_ack_after_first_frame", rx_q.size(), base + 1);
        wait_rx(base + 6, 400, "full_rx_count");
        check("full_b0", {24'd0, rx_q[base]}, 32'h01);
        check("full_b1", {24'd0, rx_q[base+1]}, 32'h80);
        check("full_b2", {24'd0, rx_q[base+2]}, 32'hFF);
        check("full_b3", {24'd0, rx_q[base+3]}, 32'h00);
        check("full_b4", {24'd0, rx_q[base+4]}, 32'hC3);
        check("full_b5", {24'd0, rx_q[base+5]}, 32'h7E);
        wait_idle(100);

        // Push lands on the very edge the FSM pops, with two bytes buffered.
        base  = rx_q.size();
        fbase = fall_q.size();
        send(8'h11, 1'b1);
        send(8'h22, 1'b1);
        send(8'h33, 1'b1);
        check("pp_count_before", {29'd0, port_in[10:8]}, 2);
        s = fall_q[fbase];
        n = 0;
        while (cyc < s + 39 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("pp_align", cyc, s + 39);
        tb_tog   = ~tb_tog;
        port_out = {tb_tog, 23'd0, 8'h44};
        @(negedge clk);
        check("pp_count_pre_edge", {29'd0, port_in[10:8]}, 2);
        @(negedge clk);
        check("pp_count_same_edge", {29'd0, port_in[10:8]}, 2);
        check("pp_ack_same_edge", {31'd0, port_in[31]}, {31'd0, tb_tog});
        check("pp_start_same_edge", {31'd0, uart_tx}, 0);
        wait_rx(base + 4, 300, "pp_rx_count");
        check("pp_b0", {24'd0, rx_q[base]}, 32'h11);
        check("pp_b1", {24'd0, rx_q[base+1]}, 32'h22);
        check("pp_b2", {24'd0, rx_q[base+2]}, 32'h33);
        check("pp_b3", {24'd0, rx_q[base+3]}, 32'h44);
        check("pp_fall_gap", fall_q[fbase+3] - fall_q[fbase+2], 41);
        wait_idle(100);

        // Asynchronous reset in the middle of a frame.
        send(8'h5A, 1'b1);
        @(negedge clk);
        check("pre_reset_tx_low", {31'd0, uart_tx}, 0);
        #2;
        reset_n  = 1'b0;
        port_out = '0;
        tb_tog   = 1'b0;
        #1;
        check("async_reset_tx", {31'd0, uart_tx}, 1);
        check("async_reset_pi", port_in, 32'h0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        early = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (uart_tx !== 1'b1 || port_in !== 32'h0) early++;
        end
        check("post_reset_quiet", early, 0);
        base = rx_q.size();
        send(8'h6B, 1'b1);
        wait_rx(base + 1, 200, "post_reset_rx_count");
        check("post_reset_byte", {24'd0, rx_q[base]}, 32'h6B);
        wait_idle(100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
